// File: rtl/cmplx_mult_pkg.sv
// Shared types and codebook constants for the complex precoder multiplier.
// Codebook entries are stored in units of 0.5 and scaled to the sample format by precoder_codebook.
package cmplx_mult_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, OUTPUT, DONE} state_t;

  localparam int NUM_SUPPORTED_CB = 3;
  localparam int CB_COLS          = 4;
  localparam int CB_LAYERS        = 2;

  // Indexed [q][j][l]
  localparam int CB_RE [0:2][0:3][0:1] = '{
    '{'{1, 1}, '{-1, 1}, '{1, 1}, '{-1, 1}},
    '{'{1, 0}, '{0, 1},  '{1, 0}, '{0, 1}},
    '{'{1, 1}, '{1, 0},  '{1, -1}, '{1, 0}}
  };

  localparam int CB_IM [0:2][0:3][0:1] = '{
    '{'{0, 0}, '{0, 0}, '{0, 0}, '{0, 0}},
    '{'{0, 0}, '{0, 0}, '{0, 0}, '{0, 0}},
    '{'{0, 0}, '{0, 1}, '{0, 0}, '{0, -1}}
  };

  function automatic int cb_coef(input int q, input int j, input int l, input bit imag);
    logic [1:0] qi;
    logic [1:0] ji;
    logic       li;
    qi = q[1:0];
    ji = j[1:0];
    li = l[0];
    if (q < 0 || q >= NUM_SUPPORTED_CB || j < 0 || j >= CB_COLS || l < 0 || l >= CB_LAYERS)
      return 0;
    return imag ? CB_IM[qi][ji][li] : CB_RE[qi][ji][li];
  endfunction

endpackage

// File: rtl/precoder_codebook.sv
// Combinational codebook lookup: (q_index, j, l) -> S[j][l] in the sample fixed-point format.
module precoder_codebook
  import cmplx_mult_pkg::*;
#(
  parameter int N      = 16,
  parameter int Q      = 8,
  parameter int NUM_CB = 16,
  parameter int COLS   = 4,
  parameter int LAYERS = 2
) (
  input  logic [$clog2(NUM_CB)-1:0]                   q_index,
  input  logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0]     j,
  input  logic [((LAYERS > 1) ? $clog2(LAYERS) : 1)-1:0] l,
  output logic signed [N-1:0]                         S_r,
  output logic signed [N-1:0]                         S_i
);

  localparam int HALF = 1 << (Q - 1);

  always_comb begin
    S_r = N'(cb_coef(int'(q_index), int'(j), int'(l), 1'b0) * HALF);
    S_i = N'(cb_coef(int'(q_index), int'(j), int'(l), 1'b1) * HALF);
  end

endmodule

// File: rtl/cmplx_precoder_mult.sv
// Streams H row-major, multiplies each row by codebook matrix S into LAYERS complex
// accumulators, buffers the rounded/saturated ROWSxLAYERS result and streams it out.
module cmplx_precoder_mult
  import cmplx_mult_pkg::*;
#(
  parameter int Q         = 8,
  parameter int N         = 16,
  parameter int ACC_WIDTH = 32,
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int LAYERS    = 2,
  parameter int NUM_CB    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [$clog2(NUM_CB)-1:0] q_index,
  input  logic                      H_in_valid,
  output logic                      H_in_ready,
  input  logic signed [N-1:0]       H_in_r,
  input  logic signed [N-1:0]       H_in_i,
  output logic                      Hq_out_valid,
  input  logic                      Hq_out_ready,
  output logic signed [N-1:0]       Hq_out_r,
  output logic signed [N-1:0]       Hq_out_i,
  output logic                      done,
  output logic                      busy,
  output logic                      q_err,
  output logic                      sat_flag
);

  localparam int QW = $clog2(NUM_CB);
  localparam int JW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int LW = (LAYERS > 1) ? $clog2(LAYERS) : 1;

  localparam logic signed [ACC_WIDTH-1:0] RND     = ACC_WIDTH'(1 << (Q - 1));
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (N - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -SAT_MAX - 1;

  state_t                 state;
  logic [QW-1:0]          q_reg;
  logic [JW-1:0]          col_cnt;
  logic [RW-1:0]          row_cnt;
  logic [RW-1:0]          out_row, nxt_row;
  logic [LW-1:0]          out_lay, nxt_lay;
  logic                   prime;
  logic                   accept, row_end, out_fire, last_out;
  logic [LAYERS-1:0]      sat_hit;
  logic signed [N-1:0]    rd_r [LAYERS];
  logic signed [N-1:0]    rd_i [LAYERS];

  assign H_in_ready = (state == LOAD);
  assign busy       = (state != IDLE);
  assign accept     = H_in_ready && H_in_valid;
  assign row_end    = accept && (col_cnt == JW'(COLS - 1));
  assign out_fire   = Hq_out_valid && Hq_out_ready;
  assign last_out   = (out_row == RW'(ROWS - 1)) && (out_lay == LW'(LAYERS - 1));

  // Read address of the element that will sit on the output after this edge.
  always_comb begin
    nxt_row = out_row;
    nxt_lay = out_lay;
    if (out_fire) begin
      if (out_lay == LW'(LAYERS - 1)) begin
        nxt_lay = '0;
        nxt_row = out_row + RW'(1);
      end else begin
        nxt_lay = out_lay + LW'(1);
      end
    end
  end

  for (genvar l = 0; l < LAYERS; l++) begin : g_layer
    logic signed [N-1:0]         s_r, s_i;
    logic signed [ACC_WIDTH-1:0] acc_r, acc_i, sum_r, sum_i, rnd_r, rnd_i;
    logic signed [N-1:0]         sat_r, sat_i;
    logic                        hi_r, lo_r, hi_i, lo_i;
    logic signed [N-1:0]         buf_r [ROWS];
    logic signed [N-1:0]         buf_i [ROWS];

    precoder_codebook #(
      .N(N), .Q(Q), .NUM_CB(NUM_CB), .COLS(COLS), .LAYERS(LAYERS)
    ) u_codebook (
      .q_index(q_reg),
      .j      (col_cnt),
      .l      (LW'(l)),
      .S_r    (s_r),
      .S_i    (s_i)
    );

    assign sum_r = acc_r + ACC_WIDTH'(H_in_r) * ACC_WIDTH'(s_r) - ACC_WIDTH'(H_in_i) * ACC_WIDTH'(s_i);
    assign sum_i = acc_i + ACC_WIDTH'(H_in_r) * ACC_WIDTH'(s_i) + ACC_WIDTH'(H_in_i) * ACC_WIDTH'(s_r);
    assign rnd_r = (sum_r + RND) >>> Q;
    assign rnd_i = (sum_i + RND) >>> Q;
    assign hi_r  = rnd_r > SAT_MAX;
    assign lo_r  = rnd_r < SAT_MIN;
    assign hi_i  = rnd_i > SAT_MAX;
    assign lo_i  = rnd_i < SAT_MIN;
    assign sat_r = hi_r ? SAT_MAX[N-1:0] : (lo_r ? SAT_MIN[N-1:0] : rnd_r[N-1:0]);
    assign sat_i = hi_i ? SAT_MAX[N-1:0] : (lo_i ? SAT_MIN[N-1:0] : rnd_i[N-1:0]);
    assign sat_hit[l] = hi_r | lo_r | hi_i | lo_i;
    assign rd_r[l] = buf_r[nxt_row];
    assign rd_i[l] = buf_i[nxt_row];

    // The last column of a row folds its own product into the rounded result.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acc_r <= '0;
        acc_i <= '0;
        buf_r <= '{default: '0};
        buf_i <= '{default: '0};
      end else if (state == IDLE && start) begin
        acc_r <= '0;
        acc_i <= '0;
      end else if (row_end) begin
        acc_r          <= '0;
        acc_i          <= '0;
        buf_r[row_cnt] <= sat_r;
        buf_i[row_cnt] <= sat_i;
      end else if (accept) begin
        acc_r <= sum_r;
        acc_i <= sum_i;
      end
    end
  end

  // Control FSM; OUTPUT spends one priming cycle so valid rises two cycles after the last load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      q_reg        <= '0;
      col_cnt      <= '0;
      row_cnt      <= '0;
      out_row      <= '0;
      out_lay      <= '0;
      prime        <= 1'b0;
      Hq_out_valid <= 1'b0;
      Hq_out_r     <= '0;
      Hq_out_i     <= '0;
      done         <= 1'b0;
      q_err        <= 1'b0;
      sat_flag     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            q_reg    <= q_index;
            q_err    <= (int'(q_index) >= NUM_SUPPORTED_CB);
            sat_flag <= 1'b0;
            col_cnt  <= '0;
            row_cnt  <= '0;
            out_row  <= '0;
            out_lay  <= '0;
            prime    <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            if (col_cnt == JW'(COLS - 1)) begin
              col_cnt <= '0;
              if (|sat_hit) sat_flag <= 1'b1;
              if (row_cnt == RW'(ROWS - 1)) state <= OUTPUT;
              else row_cnt <= row_cnt + RW'(1);
            end else begin
              col_cnt <= col_cnt + JW'(1);
            end
          end
        end
        OUTPUT: begin
          if (!Hq_out_valid) begin
            if (prime) begin
              prime        <= 1'b0;
              Hq_out_valid <= 1'b1;
              Hq_out_r     <= rd_r[nxt_lay];
              Hq_out_i     <= rd_i[nxt_lay];
            end else begin
              prime <= 1'b1;
            end
          end else if (out_fire) begin
            if (last_out) begin
              Hq_out_valid <= 1'b0;
              done         <= 1'b1;
              state        <= DONE;
            end else begin
              out_row  <= nxt_row;
              out_lay  <= nxt_lay;
              Hq_out_r <= rd_r[nxt_lay];
              Hq_out_i <= rd_i[nxt_lay];
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
